// File: rtl/mono_data_tx_emu.sv
// Monolithic pixel data-transmitter emulator: hit FIFO, freeze snapshot and
// an MSB-first serializer driven by the receiver's READ/FREEZE handshake.
module mono_data_tx_emu #(
    parameter int DATA_BITS = 24,
    parameter int DEPTH     = 16
) (
    input  logic                 CLK,
    input  logic                 RST,
    input  logic                 EN,
    input  logic                 HIT_WR,
    input  logic [DATA_BITS-1:0] HIT_DATA,
    output logic                 HIT_FULL,
    input  logic                 FREEZE,
    input  logic                 READ,
    output logic                 TOKEN,
    output logic                 DATA,
    output logic                 BUSY,
    output logic [7:0]           LOST_CNT
);
    localparam int AW   = $clog2(DEPTH);
    localparam int CNTW = AW + 1;
    localparam int CW   = $clog2(DATA_BITS);

    localparam logic [1:0] ST_IDLE  = 2'd0;
    localparam logic [1:0] ST_LOAD  = 2'd1;
    localparam logic [1:0] ST_SHIFT = 2'd2;

    logic [DATA_BITS-1:0] mem_q [DEPTH];
    logic [AW-1:0]        wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
    logic [CNTW-1:0]      count_q, count_d, frz_cnt_q, frz_cnt_d;
    logic [7:0]           lost_q, lost_d;
    logic                 freeze_ff_q, freeze_prev_q, read_ff_q, read_prev_q;
    logic                 token_q, token_d;
    logic [1:0]           state_q, state_d;
    logic [DATA_BITS-1:0] sr_q, sr_d;
    logic [CW-1:0]        bit_cnt_q, bit_cnt_d;
    logic                 full, push, pop, read_evt, frz_rise, frz_fall;

    // NOTE: every signal assigned in always_comb gets a default first so no latch is inferred.
    always_comb begin
        full     = (count_q == CNTW'(DEPTH));
        pop      = (state_q == ST_LOAD);
        push     = EN & HIT_WR & (~full | pop);
        read_evt = read_ff_q & ~read_prev_q;
        frz_rise = freeze_ff_q & ~freeze_prev_q;
        frz_fall = ~freeze_ff_q & freeze_prev_q;

        wr_ptr_d = push ? wr_ptr_q + AW'(1) : wr_ptr_q;
        rd_ptr_d = pop  ? rd_ptr_q + AW'(1) : rd_ptr_q;
        count_d  = count_q + CNTW'(push) - CNTW'(pop);

        lost_d = lost_q;
        if (EN && HIT_WR && full && !pop && lost_q != 8'hFF) begin
            lost_d = lost_q + 8'd1;
        end

        // Snapshot excludes hits arriving on the snapshot cycle itself.
        frz_cnt_d = frz_cnt_q;
        if (pop && frz_cnt_q != '0) begin
            frz_cnt_d = frz_cnt_q - CNTW'(1);
        end
        if (frz_rise) begin
            frz_cnt_d = count_q - CNTW'(pop);
        end
        if (frz_fall) begin
            frz_cnt_d = '0;
        end

        token_d = freeze_ff_q ? (frz_cnt_q != '0) : (count_q != '0);

        state_d   = state_q;
        sr_d      = sr_q;
        bit_cnt_d = bit_cnt_q;
        case (state_q)
            ST_IDLE: begin
                if (read_evt && EN && freeze_ff_q && frz_cnt_q != '0) begin
                    state_d = ST_LOAD;
                end
            end
            ST_LOAD: begin
                sr_d      = mem_q[rd_ptr_q];
                bit_cnt_d = CW'(DATA_BITS - 1);
                state_d   = ST_SHIFT;
            end
            ST_SHIFT: begin
                sr_d = {sr_q[DATA_BITS-2:0], 1'b0};
                if (bit_cnt_q == '0) begin
                    state_d = ST_IDLE;
                end else begin
                    bit_cnt_d = bit_cnt_q - CW'(1);
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // NOTE: sequential state uses non-blocking assignments only, so every flop sees pre-edge values.
    always_ff @(posedge CLK) begin
        if (RST) begin
            wr_ptr_q      <= '0;
            rd_ptr_q      <= '0;
            count_q       <= '0;
            frz_cnt_q     <= '0;
            lost_q        <= '0;
            freeze_ff_q   <= 1'b0;
            freeze_prev_q <= 1'b0;
            read_ff_q     <= 1'b0;
            read_prev_q   <= 1'b0;
            token_q       <= 1'b0;
            state_q       <= ST_IDLE;
            sr_q          <= '0;
            bit_cnt_q     <= '0;
        end else begin
            wr_ptr_q      <= wr_ptr_d;
            rd_ptr_q      <= rd_ptr_d;
            count_q       <= count_d;
            frz_cnt_q     <= frz_cnt_d;
            lost_q        <= lost_d;
            freeze_ff_q   <= FREEZE;
            freeze_prev_q <= freeze_ff_q;
            read_ff_q     <= READ;
            read_prev_q   <= read_ff_q;
            token_q       <= token_d;
            state_q       <= state_d;
            sr_q          <= sr_d;
            bit_cnt_q     <= bit_cnt_d;
        end
    end

    // NOTE: the storage array is not reset; the pointers and occupancy define what is valid.
    always_ff @(posedge CLK) begin
        if (push) begin
            mem_q[wr_ptr_q] <= HIT_DATA;
        end
    end

    assign HIT_FULL = full;
    assign TOKEN    = token_q;
    assign DATA     = (state_q == ST_SHIFT) & sr_q[DATA_BITS-1];
    assign BUSY     = (state_q != ST_IDLE);
    assign LOST_CNT = lost_q;

endmodule
